// File: rtl/rr_mux8to1.sv
// Round-robin 8-to-1 valid/ready multiplexer with per-channel enable mask.
// Each accepted word is registered and tagged with its 3-bit source channel code.
module rr_mux8to1 #(
   parameter int unsigned W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       chan_en,
   input  logic [7:0]       in_valid,
   input  logic [8*W-1:0]   in_data,
   output logic [7:0]       in_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic [2:0]       out_sel,
   input  logic             out_ready
);

   localparam int unsigned NCH = 8;

   logic [2:0]   ptr;
   logic [7:0]   elig;
   logic         load;
   logic         grant_valid;
   logic [2:0]   grant;
   logic [2:0]   idx;
   logic [W-1:0] grant_data;

   assign elig = chan_en & in_valid;
   assign load = !out_valid || out_ready;

   // Search ptr, ptr+1, ... ptr+7; descending loop lets the nearest eligible channel win.
   always_comb begin
      grant_valid = 1'b0;
      grant       = 3'd0;
      idx         = 3'd0;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = ptr + 3'(k);
         if (elig[idx]) begin
            grant_valid = 1'b1;
            grant       = idx;
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (grant == 3'(k)) grant_data = in_data[k*W +: W];
      end
   end

   // Acceptance strobe; gated by rst_n so no pulse appears while reset is held.
   always_comb begin
      in_ready = 8'd0;
      if (rst_n && load && grant_valid) in_ready = 8'(1) << grant;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= 3'd0;
         ptr       <= 3'd0;
      end else if (load) begin
         if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant;
            ptr       <= grant + 3'd1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux8to1.sv
// Directed table-driven bench for rr_mux8to1, with hand-written multi-cycle sequences.
module tb_rr_mux8to1;

   localparam int unsigned W = 8;

   logic           clk;
   logic           rst_n;
   logic [7:0]     chan_en;
   logic [7:0]     in_valid;
   logic [8*W-1:0] in_data;
   logic [7:0]     in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [2:0]     out_sel;
   logic           out_ready;

   int checks;
   int errors;

   rr_mux8to1 #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .chan_en   (chan_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] en;
      logic [7:0] valid;
      logic       ordy;
      logic [7:0] exp_ready;
      logic       exp_ov;
      logic [2:0] exp_sel;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [7:0] en, input logic [7:0] valid, input logic ordy,
                      input logic [7:0] exp_ready, input logic exp_ov, input logic [2:0] exp_sel);
      vec_t v;
      v.en = en; v.valid = valid; v.ordy = ordy;
      v.exp_ready = exp_ready; v.exp_ov = exp_ov; v.exp_sel = exp_sel;
      vecs.push_back(v);
   endtask

   task automatic set_default_data();
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = 8'(8'h10 + i);
   endtask

   // Called at posedge+1: drive, check in_ready, then check registered outputs after the edge.
   task automatic run_vec(input int i);
      string tag;
      tag = $sformatf("vec%0d", i);
      chan_en   = vecs[i].en;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ordy;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check({tag, "_out_valid"}, 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) begin
         check({tag, "_out_sel"}, 32'(out_sel), 32'(vecs[i].exp_sel));
         check({tag, "_out_data"}, 32'(out_data), 32'(8'h10) + 32'(vecs[i].exp_sel));
      end
   endtask

   task automatic step(input logic [7:0] valid, input logic ordy, input logic [7:0] exp_ready,
                       input string tag);
      in_valid  = valid;
      out_ready = ordy;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
      @(posedge clk); #1;
   endtask

   initial begin
      int split;
      checks = 0;
      errors = 0;

      // Part 1: fairness after reset, then drain.
      for (int i = 0; i < 8; i++) add(8'hFF, 8'hFF, 1'b1, 8'(1) << i, 1'b1, 3'(i));
      add(8'hFF, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0);
      add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
      split = vecs.size();
      // Part 2 starts with ptr = 0 and an empty register: backpressure.
      add(8'hFF, 8'h09, 1'b0, 8'h01, 1'b1, 3'd0);
      for (int i = 0; i < 4; i++) add(8'hFF, 8'h08, 1'b0, 8'h00, 1'b1, 3'd0);
      add(8'hFF, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3);
      add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
      // Mask out channels 0 and 3, ptr = 4.
      add(8'hF6, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4);
      add(8'hF6, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5);
      add(8'hF6, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6);
      add(8'hF6, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7);
      add(8'hF6, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1);
      add(8'hF6, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2);
      add(8'hF6, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4);
      add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
      // Wrap: channel 6 grant sets ptr = 7, then 7, 0, and ptr = 1 picks channel 1 over 0.
      add(8'hFF, 8'h40, 1'b1, 8'h40, 1'b1, 3'd6);
      add(8'hFF, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7);
      add(8'hFF, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0);
      add(8'hFF, 8'h03, 1'b1, 8'h02, 1'b1, 3'd1);
      add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);

      // Reset and idle.
      rst_n     = 1'b0;
      chan_en   = 8'hFF;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      set_default_data();
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_out_sel", 32'(out_sel), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < split; i++) run_vec(i);

      // Single source on channel 5, then channels 2 and 7 prove ptr = 6.
      in_data[5*W +: W] = 8'hA5;
      chan_en = 8'hFF;
      step(8'h20, 1'b1, 8'h20, "single");
      check("single_out_valid", 32'(out_valid), 32'h1);
      check("single_out_sel", 32'(out_sel), 32'h5);
      check("single_out_data", 32'(out_data), 32'hA5);
      step(8'h00, 1'b1, 8'h00, "single_idle");
      check("single_drain", 32'(out_valid), 32'h0);
      step(8'h84, 1'b1, 8'h80, "ptr6_first");
      check("ptr6_first_sel", 32'(out_sel), 32'h7);
      step(8'h84, 1'b1, 8'h04, "ptr6_second");
      check("ptr6_second_sel", 32'(out_sel), 32'h2);
      check("ptr6_second_data", 32'(out_data), 32'h12);
      set_default_data();
      step(8'h80, 1'b1, 8'h80, "ptr_fix");
      check("ptr_fix_sel", 32'(out_sel), 32'h7);
      step(8'h00, 1'b1, 8'h00, "ptr_fix_idle");

      for (int i = split; i < vecs.size(); i++) run_vec(i);

      // Reset mid-stream: ptr = 2 here, so a stalled channel-2 word is pending.
      step(8'hFF, 1'b0, 8'h04, "mid_load");
      check("mid_load_valid", 32'(out_valid), 32'h1);
      check("mid_load_sel", 32'(out_sel), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'h0);
      check("mid_rst_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      check("mid_rst_hold_ready", 32'(in_ready), 32'h0);
      rst_n = 1'b1;
      step(8'h30, 1'b1, 8'h10, "post_rst");
      check("post_rst_valid", 32'(out_valid), 32'h1);
      check("post_rst_sel", 32'(out_sel), 32'h4);
      check("post_rst_data", 32'(out_data), 32'h14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux8to1.md
# rr_mux8to1

Round-robin 8-to-1 channel multiplexer: the collecting counterpart of the 1-to-8 demux. Eight independent valid/ready source channels compete for one registered output stream; each accepted word leaves tagged with its 3-bit channel code {a,b,c}, so a downstream 1-to-8 demux can route it back out. Arbitration is fair round-robin with a per-channel enable mask, and the single-entry output register supports full throughput.

## Interface
- W, 8: data width per channel.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- chan_en  input  8  per-channel enable. A disabled channel is never granted.
- in_valid  input  8  bit i: channel i offers a word.
- in_data  input  8*W  channel i data on bits [i*W +: W].
- in_ready  output  8  bit i: channel i word accepted this cycle. Combinational and one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered data.
- out_sel  output  3  registered source channel code: a = out_sel[2], b = out_sel[1], c = out_sel[0].
- out_ready  input  1  sink accepts the word this cycle.

## Operation
- State: output register (out_valid, out_data, out_sel) and 3-bit round-robin pointer ptr.
- Eligible channel: chan_en[i] & in_valid[i].
- Load condition: load = !out_valid | out_ready. The register is empty, or it is being drained this cycle.
- Arbitration when load = 1: grant goes to the first eligible channel searching ptr, ptr+1, …, ptr+7, mod 8.
- in_ready[grant] = 1 and all other bits = 0. If there is no eligible channel, or load = 0, in_ready = 0.
- On a grant, at the clock edge:
  - out_data <= in_data[grant].
  - out_sel <= grant.
  - out_valid <= 1.
  - ptr <= grant+1 (7 wraps to 0).
- When load = 1 with no grant:
  - out_valid <= 0 if it was draining.
  - out_data and out_sel hold their values.
  - ptr holds.
- When load = 0 (out_valid = 1 and out_ready = 0), everything holds. Stalls are fully stable.
- Simultaneous drain and refill in the same cycle is legal and gives back-to-back words.
- A chan_en change takes effect the same cycle (combinational mask). A word already in the output register is unaffected.
- in_ready has no dependence on in_valid of other channels beyond arbitration, and no dependence on data.
- Width rule: out_sel is exactly 3 bits, and the grant index is always 0..7.

## Timing
- Reset (rst_n = 0, asynchronous): out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, in_ready = 0.
- in_ready is held 0 while rst_n = 0.
- Release: the first grant is possible in the first cycle with rst_n = 1.
- Latency: a word accepted at edge N appears on out_data/out_sel after edge N. This is 1 cycle.
- Throughput: 1 word/cycle when out_ready is held 1.
- Fairness: with all 8 channels continuously eligible, grants run 0,1,…,7,0,… Each channel waits at most 7 grants.
- Reset mid-operation: the pending output word is discarded and ptr returns to 0. No in_ready pulse occurs during reset.

## Test plan
- Reset and idle:
  - Stimulus: rst_n low with in_valid = 8'hFF.
  - Response: in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0.
  - Then release with all eligible and out_ready = 1: out_sel sequence is 0,1,2,…,7,0 on consecutive cycles, and out_data matches channel data 8'h10+i.
- Single source:
  - Stimulus: only channel 5 valid, data 8'hA5, chan_en = 8'hFF.
  - Response: in_ready = 8'h20 for one cycle. The next cycle shows out_valid = 1, out_sel = 3'b101, out_data = 8'hA5.
  - ptr = 6, proven by then raising channels 2 and 7 together: channel 7 is granted first, then channel 2.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 4 cycles with channels 0 and 3 valid.
  - Response: out_data/out_sel/out_valid stable and in_ready = 0 throughout.
  - Raise out_ready: words drain in order 0, 3 with no gap and no loss.
- Mask:
  - Stimulus: chan_en = 8'b1111_0110 with all valid.
  - Response: the grant sequence only includes channels 1,2,4,5,6,7,1,…; channels 0 and 3 never see in_ready.
- Wrap:
  - Stimulus: ptr = 7 (after a channel-6 grant), with channels 7 and 0 valid.
  - Response: channel 7 is granted first, then channel 0, and ptr returns to 1.
- Reset mid-stream:
  - Stimulus: assert rst_n low asynchronously between edges while out_valid = 1.
  - Response: out_valid drops immediately. After release, the first grant is the lowest-indexed eligible channel.
